// File: rtl/delay_line_pkg.sv
// Shared defaults for the data delay line and a helper sizing the occupancy counter.
package delay_line_pkg;

    localparam int unsigned DEFAULT_WORD_LENGTH = 4;
    localparam int unsigned DEFAULT_DEPTH       = 4;

    function automatic int unsigned fill_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ffd_en_stage.sv
// One delay-line stage: data register plus valid flag with sync reset,
// load enable and a valid-only clear that leaves the data untouched.
module ffd_en_stage #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear_valid,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;

    // clear_valid outranks enable so a flush never lets new data in.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clear_valid) begin
            valid_d = 1'b0;
        end else if (enable) begin
            data_d  = d;
            valid_d = d_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q       = data_q;
    assign q_valid = valid_q;

endmodule

// File: rtl/data_delay_line.sv
// Fixed-latency data delay line with per-stage valid flags, flush and an
// occupancy count; no backpressure, the oldest word simply falls off the end.
module data_delay_line
    import delay_line_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = DEFAULT_WORD_LENGTH,
    parameter int unsigned DEPTH       = DEFAULT_DEPTH
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              flush,
    input  logic [WORD_LENGTH-1:0]            d,
    input  logic                              d_valid,
    output logic [WORD_LENGTH-1:0]            data_out,
    output logic                              out_valid,
    output logic [fill_width(DEPTH)-1:0]      fill_count,
    output logic                              full
);

    localparam int unsigned FCW = fill_width(DEPTH);

    typedef struct packed {
        logic [WORD_LENGTH-1:0] data;
        logic                   valid;
    } stage_t;

    stage_t stage_in  [DEPTH];
    stage_t stage_out [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign stage_in[g] = '{data: d, valid: d_valid};
        end else begin : g_body
            assign stage_in[g] = stage_out[g-1];
        end

        ffd_en_stage #(
            .WIDTH (WORD_LENGTH)
        ) u_stage (
            .clock       (clock),
            .reset       (reset),
            .enable      (enable),
            .clear_valid (flush),
            .d           (stage_in[g].data),
            .d_valid     (stage_in[g].valid),
            .q           (stage_out[g].data),
            .q_valid     (stage_out[g].valid)
        );
    end

    logic [FCW-1:0] fill_count_d, fill_count_q;

    // Modular add/sub is safe: the true result always lies in 0..DEPTH.
    always_comb begin
        fill_count_d = fill_count_q;
        if (flush) begin
            fill_count_d = '0;
        end else if (enable) begin
            fill_count_d = fill_count_q + FCW'(d_valid) - FCW'(stage_out[DEPTH-1].valid);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fill_count_q <= '0;
        end else begin
            fill_count_q <= fill_count_d;
        end
    end

    assign data_out   = stage_out[DEPTH-1].data;
    assign out_valid  = stage_out[DEPTH-1].valid;
    assign fill_count = fill_count_q;
    assign full       = (fill_count_q == FCW'(DEPTH));

endmodule

// File: tb/tb_data_delay_line.sv
// Directed bench for data_delay_line: a queue holding the expected pipeline
// contents is advanced alongside the stimulus and its head checked each edge.
module tb_data_delay_line;

    localparam int unsigned WL    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FCW   = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic [WL-1:0] d = '0;
    logic          d_valid = 1'b0;
    logic [WL-1:0] data_out;
    logic          out_valid;
    logic [FCW-1:0] fill_count;
    logic          full;

    int n_cmp = 0;
    int n_err = 0;

    logic [WL:0] model [$];

    always #5 clock = ~clock;

    data_delay_line #(
        .WORD_LENGTH (WL),
        .DEPTH       (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .flush      (flush),
        .d          (d),
        .d_valid    (d_valid),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .fill_count (fill_count),
        .full       (full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        model.delete();
        for (int i = 0; i < DEPTH; i++) model.push_back('0);
    endtask

    task automatic check_outputs(input string tag);
        int unsigned cnt;
        logic [WL:0] head;
        cnt = 0;
        foreach (model[i]) cnt += model[i][0];
        head = model[0];
        check({tag, ".data_out"},   32'(data_out),   32'(head[WL:1]));
        check({tag, ".out_valid"},  32'(out_valid),  32'(head[0]));
        check({tag, ".fill_count"}, 32'(fill_count), cnt);
        check({tag, ".full"},       32'(full),       32'(cnt == DEPTH));
    endtask

    // Drive one edge's inputs, advance the expected pipeline, then sample.
    task automatic step(input string tag, input logic rst, input logic en, input logic fl,
                        input logic [WL-1:0] dd, input logic dv);
        logic [WL:0] dropped;
        reset = rst; enable = en; flush = fl; d = dd; d_valid = dv;
        @(posedge clock);
        if (rst) begin
            model_reset();
        end else if (fl) begin
            foreach (model[i]) model[i][0] = 1'b0;
        end else if (en) begin
            model.push_back({dd, dv});
            dropped = model.pop_front();
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        @(negedge clock);

        // Reset for two cycles then idle.
        step("rst0", 1, 0, 0, 4'h0, 0);
        step("rst1", 1, 0, 0, 4'h0, 0);
        step("idle", 0, 0, 0, 4'h0, 0);

        // Fill with 5,1,3,9 then drain with invalid words.
        step("fill0", 0, 1, 0, 4'h5, 1);
        step("fill1", 0, 1, 0, 4'h1, 1);
        step("fill2", 0, 1, 0, 4'h3, 1);
        step("fill3", 0, 1, 0, 4'h9, 1);
        check("full_after_fill", 32'(full), 32'd1);
        check("head_after_fill", 32'(data_out), 32'h5);
        for (int i = 0; i < 4; i++) step("drain", 0, 1, 0, 4'h0, 0);

        // Stall in the middle of a stream.
        step("srst", 1, 0, 0, 4'h0, 0);
        step("s0", 0, 1, 0, 4'h5, 1);
        step("s1", 0, 1, 0, 4'h1, 1);
        for (int i = 0; i < 3; i++) step("stall", 0, 0, 0, 4'hA, 1);
        step("s2", 0, 1, 0, 4'h0, 0);
        step("s3", 0, 1, 0, 4'h0, 0);
        check("stall_latency", 32'(data_out), 32'h5);

        // Flush a full pipe with enable also asserted.
        step("frst", 1, 0, 0, 4'h0, 0);
        step("f0", 0, 1, 0, 4'h2, 1);
        step("f1", 0, 1, 0, 4'h4, 1);
        step("f2", 0, 1, 0, 4'h6, 1);
        step("f3", 0, 1, 0, 4'h8, 1);
        step("flush", 0, 1, 1, 4'h7, 1);
        check("flush_data_hold", 32'(data_out), 32'h2);
        step("post_flush", 0, 1, 0, 4'hC, 1);

        // Alternating valid pattern.
        step("arst", 1, 0, 0, 4'h0, 0);
        for (int i = 0; i < 8; i++) step("alt", 0, 1, 0, 4'(i + 1), (i % 2) == 0);
        check("alt_fill_settle", 32'(fill_count), 32'd2);

        // Reset mid-stream with enable and new data presented.
        step("r0", 0, 1, 0, 4'h1, 1);
        step("r1", 0, 1, 0, 4'h2, 1);
        step("r2", 0, 1, 0, 4'h3, 1);
        step("r3", 0, 1, 0, 4'h4, 1);
        step("mid_reset", 1, 1, 1, 4'hF, 1);
        check("reset_wipes_fill", 32'(fill_count), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            step("after_reset", 0, 1, 0, 4'h0, 0);
            check("no_F_leak", 32'(data_out == 4'hF), 32'd0);
        end

        // Random tail exercising mixed enable/flush.
        for (int i = 0; i < 40; i++)
            step("rand", 0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                 4'($urandom), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
